// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_pkg
// Purpose  : ALU function codes, opcodes, operand selects and decode bundle.
// Revision : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    localparam logic [3:0] FUNC_ADD  = 4'b0000;
    localparam logic [3:0] FUNC_SUB  = 4'b0001;
    localparam logic [3:0] FUNC_XOR  = 4'b0010;
    localparam logic [3:0] FUNC_OR   = 4'b0011;
    localparam logic [3:0] FUNC_AND  = 4'b0100;
    localparam logic [3:0] FUNC_SLTU = 4'b0101;
    localparam logic [3:0] FUNC_SLT  = 4'b0110;
    localparam logic [3:0] FUNC_SLL  = 4'b0111;
    localparam logic [3:0] FUNC_SRL  = 4'b1000;
    localparam logic [3:0] FUNC_SRA  = 4'b1001;
    localparam logic [3:0] FUNC_EQ   = 4'b1010;
    localparam logic [3:0] FUNC_NE   = 4'b1011;
    localparam logic [3:0] FUNC_GEU  = 4'b1100;
    localparam logic [3:0] FUNC_GE   = 4'b1101;
    localparam logic [3:0] FUNC_PC4  = 4'b1110;
    localparam logic [3:0] FUNC_PASS = 4'b1111;

    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;

    localparam logic SRC1_RS1 = 1'b0;
    localparam logic SRC1_PC  = 1'b1;
    localparam logic SRC2_RS2 = 1'b0;
    localparam logic SRC2_IMM = 1'b1;

    typedef struct packed {
        logic [3:0]  func;
        logic        src1_sel;
        logic        src2_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic        is_branch;
        logic        is_jump;
        logic        is_load;
        logic        is_store;
        logic [2:0]  mem_size;
        logic        illegal;
        logic [31:0] pc;
    } dec_bundle_t;

    // alt selects SUB (funct3=000) or SRA (funct3=101); ignored elsewhere
    function automatic logic [3:0] alu_func(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_func = alt ? FUNC_SUB : FUNC_ADD;
            3'b001:  alu_func = FUNC_SLL;
            3'b010:  alu_func = FUNC_SLT;
            3'b011:  alu_func = FUNC_SLTU;
            3'b100:  alu_func = FUNC_XOR;
            3'b101:  alu_func = alt ? FUNC_SRA : FUNC_SRL;
            3'b110:  alu_func = FUNC_OR;
            default: alu_func = FUNC_AND;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_imm_gen.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_imm_gen
// Purpose  : Sign-extended immediate for the instruction's encoding format.
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;

    assign w_imm_i = {{20{instr[31]}}, instr[31:20]};
    assign w_imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign w_imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign w_imm_u = {instr[31:12], 12'b0};
    assign w_imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        imm = 32'b0;
        case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm = w_imm_i;
            OPC_STORE:                      imm = w_imm_s;
            OPC_BRANCH:                     imm = w_imm_b;
            OPC_LUI, OPC_AUIPC:             imm = w_imm_u;
            OPC_JAL:                        imm = w_imm_j;
            default:                        imm = 32'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rv32i_alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_alu_ctrl_decode
// Purpose  : RV32I decode to ALU control bundle behind a 2-entry skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_alu_ctrl_decode
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_func,
    output logic            out_src1_sel,
    output logic            out_src2_sel,
    output logic [31:0]     out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic            out_is_branch,
    output logic            out_is_jump,
    output logic            out_is_load,
    output logic            out_is_store,
    output logic [2:0]      out_mem_size,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc
);

    logic [31:0] w_imm;
    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic        w_legal;
    logic        w_we;
    logic        w_accept;
    dec_bundle_t w_dec;
    dec_bundle_t r_main;
    dec_bundle_t r_skid;
    logic        r_main_valid;
    logic        r_skid_valid;

    rv32i_imm_gen u_imm_gen (
        .instr (in_instr),
        .imm   (w_imm)
    );

    assign w_opc = in_instr[6:0];
    assign w_f3  = in_instr[14:12];
    assign w_f7  = in_instr[31:25];

    always_comb begin
        w_dec     = '0;
        w_dec.imm = w_imm;
        w_dec.rs1 = in_instr[19:15];
        w_dec.rs2 = in_instr[24:20];
        w_dec.rd  = in_instr[11:7];
        w_dec.pc  = in_pc;
        w_legal   = 1'b1;
        w_we      = 1'b0;
        case (w_opc)
            OPC_OP: begin
                w_we       = 1'b1;
                w_dec.func = alu_func(w_f3, w_f7[5]);
                w_legal    = (w_f7 == 7'b0000000) ||
                             ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                w_we           = 1'b1;
                w_dec.src2_sel = SRC2_IMM;
                w_dec.func     = alu_func(w_f3, (w_f3 == 3'b101) && w_f7[5]);
                if (w_f3 == 3'b001)
                    w_legal = (w_f7 == 7'b0000000);
                else if (w_f3 == 3'b101)
                    w_legal = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
            end
            OPC_LOAD: begin
                w_we           = 1'b1;
                w_dec.src2_sel = SRC2_IMM;
                w_dec.is_load  = 1'b1;
                w_dec.mem_size = w_f3;
                w_legal        = !((w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111));
            end
            OPC_STORE: begin
                w_dec.src2_sel = SRC2_IMM;
                w_dec.is_store = 1'b1;
                w_dec.mem_size = w_f3;
                w_legal        = (w_f3 < 3'b011);
            end
            OPC_BRANCH: begin
                w_dec.is_branch = 1'b1;
                case (w_f3)
                    3'b000:  w_dec.func = FUNC_EQ;
                    3'b001:  w_dec.func = FUNC_NE;
                    3'b100:  w_dec.func = FUNC_SLT;
                    3'b101:  w_dec.func = FUNC_GE;
                    3'b110:  w_dec.func = FUNC_SLTU;
                    3'b111:  w_dec.func = FUNC_GEU;
                    default: w_legal    = 1'b0;
                endcase
            end
            OPC_JAL, OPC_JALR: begin
                w_we           = 1'b1;
                w_dec.func     = FUNC_PC4;
                w_dec.src1_sel = SRC1_PC;
                w_dec.is_jump  = 1'b1;
                w_legal        = (w_opc == OPC_JAL) || (w_f3 == 3'b000);
            end
            OPC_LUI: begin
                w_we           = 1'b1;
                w_dec.func     = FUNC_PASS;
                w_dec.src2_sel = SRC2_IMM;
            end
            OPC_AUIPC: begin
                w_we           = 1'b1;
                w_dec.src1_sel = SRC1_PC;
                w_dec.src2_sel = SRC2_IMM;
            end
            OPC_MISCMEM: w_dec.func = FUNC_ADD;
            default:     w_legal    = 1'b0;
        endcase
        w_dec.rd_we = w_we && (w_dec.rd != 5'd0);
        if (!w_legal) begin
            w_dec.func      = FUNC_PASS;
            w_dec.src1_sel  = SRC1_RS1;
            w_dec.src2_sel  = SRC2_RS2;
            w_dec.rd_we     = 1'b0;
            w_dec.is_branch = 1'b0;
            w_dec.is_jump   = 1'b0;
            w_dec.is_load   = 1'b0;
            w_dec.is_store  = 1'b0;
            w_dec.mem_size  = 3'b0;
            w_dec.illegal   = 1'b1;
        end
    end

    // The skid entry only fills while main is stalled, so ready is its empty flag.
    assign in_ready = !r_skid_valid;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid || out_ready) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_main_valid <= w_accept;
                if (w_accept)
                    r_main <= w_dec;
            end
        end else if (w_accept) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end

    assign out_valid     = r_main_valid;
    assign out_func      = r_main.func;
    assign out_src1_sel  = r_main.src1_sel;
    assign out_src2_sel  = r_main.src2_sel;
    assign out_imm       = r_main.imm;
    assign out_rs1       = r_main.rs1;
    assign out_rs2       = r_main.rs2;
    assign out_rd        = r_main.rd;
    assign out_rd_we     = r_main.rd_we;
    assign out_is_branch = r_main.is_branch;
    assign out_is_jump   = r_main.is_jump;
    assign out_is_load   = r_main.is_load;
    assign out_is_store  = r_main.is_store;
    assign out_mem_size  = r_main.mem_size;
    assign out_illegal   = r_main.illegal;
    assign out_pc        = r_main.pc;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_alu_ctrl_decode
// Purpose  : Scoreboard bench for the RV32I decode stage and its skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_alu_ctrl_decode;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'b0;
    logic [31:0] in_pc = 32'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_func;
    logic        out_src1_sel;
    logic        out_src2_sel;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        out_is_branch;
    logic        out_is_jump;
    logic        out_is_load;
    logic        out_is_store;
    logic [2:0]  out_mem_size;
    logic        out_illegal;
    logic [31:0] out_pc;

    rv32i_alu_ctrl_decode #(.XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_func      (out_func),
        .out_src1_sel  (out_src1_sel),
        .out_src2_sel  (out_src2_sel),
        .out_imm       (out_imm),
        .out_rs1       (out_rs1),
        .out_rs2       (out_rs2),
        .out_rd        (out_rd),
        .out_rd_we     (out_rd_we),
        .out_is_branch (out_is_branch),
        .out_is_jump   (out_is_jump),
        .out_is_load   (out_is_load),
        .out_is_store  (out_is_store),
        .out_mem_size  (out_mem_size),
        .out_illegal   (out_illegal),
        .out_pc        (out_pc)
    );

    always #5 clk = ~clk;

    // func[93:90] s1[89] s2[88] imm[87:56] rs1[55:51] rs2[50:46] rd[45:41]
    // we[40] br[39] j[38] ld[37] st[36] msize[35:33] ill[32] pc[31:0]
    logic [93:0] w_obs;
    assign w_obs = {out_func, out_src1_sel, out_src2_sel, out_imm, out_rs1, out_rs2, out_rd,
                    out_rd_we, out_is_branch, out_is_jump, out_is_load, out_is_store,
                    out_mem_size, out_illegal, out_pc};

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [93:0] val;
        logic [93:0] mask;
    } item_t;

    item_t tab [19];
    int    sb [$];
    int    n_chk = 0;
    int    n_fail = 0;

    // dc = {s1, s2, imm, rs1, rs2, rd}: 1 marks a field the instruction leaves undefined
    function automatic item_t mk(input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [3:0] f, input logic s1, input logic s2,
                                 input logic [31:0] imm, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic we, input logic br, input logic j,
                                 input logic ld, input logic st, input logic [2:0] ms,
                                 input logic ill, input logic [5:0] dc);
        item_t it;
        it.instr = instr;
        it.pc    = pc;
        it.val   = {f, s1, s2, imm, rs1, rs2, rd, we, br, j, ld, st, ms, ill, pc};
        it.mask  = '1;
        if (dc[5]) it.mask[89] = 1'b0;
        if (dc[4]) it.mask[88] = 1'b0;
        if (dc[3]) it.mask[87:56] = '0;
        if (dc[2]) it.mask[55:51] = '0;
        if (dc[1]) it.mask[50:46] = '0;
        if (dc[0]) it.mask[45:41] = '0;
        if (!(ld || st)) it.mask[35:33] = '0;
        return it;
    endfunction

    task automatic build_table();
        tab[0]  = mk(32'h002081B3, 32'h000, 4'h0, 0, 0, 32'h0,        1, 2, 3, 1, 0, 0, 0, 0, 3'd0, 0, 6'b001000);
        tab[1]  = mk(32'h407302B3, 32'h004, 4'h1, 0, 0, 32'h0,        6, 7, 5, 1, 0, 0, 0, 0, 3'd0, 0, 6'b001000);
        tab[2]  = mk(32'hFFF00093, 32'h008, 4'h0, 0, 1, 32'hFFFFFFFF, 0, 0, 1, 1, 0, 0, 0, 0, 3'd0, 0, 6'b000010);
        tab[3]  = mk(32'h008000EF, 32'h100, 4'hE, 1, 0, 32'h8,        0, 0, 1, 1, 0, 1, 0, 0, 3'd0, 0, 6'b010110);
        tab[4]  = mk(32'hFFFFFFFF, 32'h010, 4'hF, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 6'b111111);
        tab[5]  = mk(32'h00000073, 32'h014, 4'hF, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 6'b111111);
        tab[6]  = mk(32'hFFC12283, 32'h018, 4'h0, 0, 1, 32'hFFFFFFFC, 2, 0, 5, 1, 0, 0, 1, 0, 3'd2, 0, 6'b000010);
        tab[7]  = mk(32'h00612423, 32'h01C, 4'h0, 0, 1, 32'h8,        2, 6, 0, 0, 0, 0, 0, 1, 3'd2, 0, 6'b000001);
        tab[8]  = mk(32'hFE209EE3, 32'h020, 4'hB, 0, 0, 32'hFFFFFFFC, 1, 2, 0, 0, 1, 0, 0, 0, 3'd0, 0, 6'b000001);
        tab[9]  = mk(32'h123453B7, 32'h024, 4'hF, 0, 1, 32'h12345000, 0, 0, 7, 1, 0, 0, 0, 0, 3'd0, 0, 6'b100110);
        tab[10] = mk(32'hFFFFF217, 32'h200, 4'h0, 1, 1, 32'hFFFFF000, 0, 0, 4, 1, 0, 0, 0, 0, 3'd0, 0, 6'b000110);
        tab[11] = mk(32'h40315093, 32'h028, 4'h9, 0, 1, 32'h00000403, 2, 0, 1, 1, 0, 0, 0, 0, 3'd0, 0, 6'b000010);
        tab[12] = mk(32'h40311093, 32'h02C, 4'hF, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 6'b111111);
        tab[13] = mk(32'h00208033, 32'h030, 4'h0, 0, 0, 32'h0,        1, 2, 0, 0, 0, 0, 0, 0, 3'd0, 0, 6'b001000);
        tab[14] = mk(32'h0041E863, 32'h034, 4'h5, 0, 0, 32'h10,       3, 4, 0, 0, 1, 0, 0, 0, 3'd0, 0, 6'b000001);
        tab[15] = mk(32'h004280E7, 32'h038, 4'hE, 1, 0, 32'h4,        5, 0, 1, 1, 0, 1, 0, 0, 3'd0, 0, 6'b010010);
        tab[16] = mk(32'h0000000F, 32'h03C, 4'h0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 6'b111111);
        tab[17] = mk(32'h00013283, 32'h040, 4'hF, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 6'b111111);
        tab[18] = mk(32'h02A4E433, 32'h044, 4'hF, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 6'b111111);
    endtask

    // mode 0: out_ready held high; 1: random ready/valid; 2: ready low for 3 cycles
    task automatic run_stream(input int first, input int last, input int mode);
        int          idx = first;
        int          cyc = 0;
        int          e;
        logic        hold = 1'b0;
        logic [93:0] prev = '0;
        while ((idx <= last || sb.size() != 0) && cyc < 600) begin
            @(negedge clk);
            if (hold) begin
                n_chk++;
                if (out_valid !== 1'b1 || w_obs !== prev) begin
                    n_fail++;
                    $display("FAIL hold_stable: got valid=%b %h required valid=1 %h", out_valid, w_obs, prev);
                end
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (cyc >= 3);
            endcase
            in_valid = (idx <= last) && (mode != 1 || $urandom_range(0, 3) != 0);
            if (idx <= last) begin
                in_instr = tab[idx].instr;
                in_pc    = tab[idx].pc;
            end
            #1;
            if (mode == 2 && cyc == 2) begin
                n_chk++;
                if (in_ready !== 1'b0 || idx - first != 2) begin
                    n_fail++;
                    $display("FAIL skid_full: got in_ready=%b accepted=%0d required in_ready=0 accepted=2", in_ready, idx - first);
                end
            end
            if (out_valid && out_ready) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_bundle: got %h required no output", w_obs);
                end else begin
                    e = sb.pop_front();
                    if ((w_obs & tab[e].mask) !== (tab[e].val & tab[e].mask)) begin
                        n_fail++;
                        $display("FAIL bundle[%0d]: got %h required %h (mask %h)", e, w_obs & tab[e].mask, tab[e].val & tab[e].mask, tab[e].mask);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(idx);
                idx++;
            end
            hold = out_valid && !out_ready;
            prev = w_obs;
            cyc++;
        end
        in_valid = 1'b0;
        if (cyc >= 600) begin
            n_chk++;
            n_fail++;
            $display("FAIL stream_timeout: got %0d pending required 0", sb.size() + last + 1 - idx);
            sb.delete();
        end
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL no_duplicate: got out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        n_chk++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        n_chk++;
        if (w_obs !== '0) begin n_fail++; $display("FAIL reset_fields: got %h required 0", w_obs); end
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: got in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = tab[0].instr;
        in_pc     = tab[0].pc;
        #1;
        n_chk++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_pre: got out_valid=%b required 0", out_valid); end
        @(negedge clk);
        in_valid = 1'b0;
        n_chk++;
        if (out_valid !== 1'b1 || out_func !== 4'h0 || out_rd !== 5'd3 || out_rd_we !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_one: got valid=%b func=%h rd=%0d we=%b required 1 0 3 1", out_valid, out_func, out_rd, out_rd_we);
        end
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_drain: got out_valid=%b required 0", out_valid); end
    endtask

    task automatic test_decode();
        run_stream(0, 18, 0);
    endtask

    task automatic test_backpressure();
        run_stream(0, 3, 2);
    endtask

    task automatic test_back_to_back();
        run_stream(0, 18, 1);
        run_stream(0, 18, 1);
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = tab[0].instr;
        in_pc     = tab[0].pc;
        @(negedge clk);
        in_instr = tab[1].instr;
        in_pc    = tab[1].pc;
        @(negedge clk);
        n_chk++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_fill: got in_ready=%b out_valid=%b required 0 1", in_ready, out_valid);
        end
        flush    = 1'b1;
        in_instr = tab[2].instr;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_full: got out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        in_valid = 1'b1;
        in_instr = tab[3].instr;
        @(negedge clk);
        flush    = 1'b1;
        in_instr = tab[4].instr;
        @(negedge clk);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_drops_input: got out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = tab[6].instr;
        in_pc     = tab[6].pc;
        @(negedge clk);
        in_instr = tab[7].instr;
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || w_obs !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got valid=%b ready=%b %h required 0 1 0", out_valid, in_ready, w_obs);
        end
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        build_table();
        test_reset();
        test_latency();
        test_decode();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_decode();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv32i_alu_ctrl_decode.md
Name: rv32i_alu_ctrl_decode

Overview:
- Decode stage that produces the 4-bit ALU function code and operand selects consumed by the RV32I ALU.
- Takes a fetched 32-bit instruction plus its PC over a valid/ready handshake and emits a registered decode bundle: func, selects, immediate, register indices and control flags.
- Sits between fetch and register read/execute.
- Has a 2-entry skid buffer, so it sustains one instruction per cycle under back-pressure.

Parameters:
- XLEN, 32, data/PC width (only 32 is supported).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active low
- in_valid  in  1  instruction available
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address
- flush  in  1  kill all held entries
- out_valid  out  1  decode bundle valid
- out_ready  in  1  execute accepts bundle
- out_func  out  4  ALU function code
- out_src1_sel  out  1  0=rs1, 1=pc
- out_src2_sel  out  1  0=rs2, 1=imm
- out_imm  out  32  sign-extended immediate
- out_rs1, out_rs2, out_rd  out  5 each  register indices
- out_rd_we  out  1  register writeback enable
- out_is_branch, out_is_jump, out_is_load, out_is_store  out  1 each
- out_mem_size  out  3  funct3 for loads/stores
- out_illegal  out  1  illegal or system instruction
- out_pc  out  XLEN  PC of the bundle

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset (rst_n=0 at a rising edge):
  - out_valid=0 and both skid entries are empty.
  - in_ready=1 from the first cycle after reset.
  - All bundle fields are 0.
- Handshake:
  - Transfer occurs on an edge where valid&&ready.
  - out_valid does not depend combinationally on out_ready; in_ready is registered.
  - Latency is 1 cycle: an instruction accepted at edge N is on the outputs after edge N.
- Skid buffer:
  - Main register plus one skid register.
  - in_ready = skid entry empty.
  - If out_ready=0 while main is full and an input is accepted, the input goes to skid.
  - When main drains, skid moves to main.
  - Bundles leave in strict acceptance order.
  - Outputs hold stable while out_valid&&!out_ready.
- Flush:
  - Clears both entries at the edge; any input offered that same cycle is dropped.
  - in_ready=1 next cycle.
  - Flush takes priority over accept.
- Func codes, fixed:
  - ADD 0000, SUB 0001, XOR 0010, OR 0011, AND 0100, SLTU 0101, SLT 0110, SLL 0111
  - SRL 1000, SRA 1001, EQ 1010, NE 1011, GEU 1100, GE 1101, PC4 1110, PASS 1111
- Opcode mapping:
  - OP (0110011): funct3/funct7 select ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND. funct7 must be 0000000, except 0100000 for SUB/SRA; anything else is illegal.
  - OP-IMM (0010011): same mapping with src2=imm and no SUB. For shifts, imm[11:5] must be 0000000 (or 0100000 for SRAI), else illegal.
  - LOAD (0000011) and STORE (0100011): ADD, src2=imm. Store has rd_we=0. Load funct3 011/110/111 and store funct3 ≥011 are illegal.
  - BRANCH (1100011): BEQ→EQ, BNE→NE, BLT→SLT, BGE→GE, BLTU→SLTU, BGEU→GEU. src2=rs2, rd_we=0. funct3 010/011 are illegal.
  - JAL (1101111): PC4, src1=pc, is_jump.
  - JALR (1100111): PC4, src1=pc, is_jump. funct3≠000 is illegal.
  - LUI (0110111): PASS, src2=imm.
  - AUIPC (0010111): ADD, src1=pc, src2=imm.
  - MISC-MEM (0001111): NOP, i.e. ADD with rd_we=0.
  - SYSTEM (1110011) and any other opcode: illegal.
- Illegal instructions: out_illegal=1, func=PASS, rd_we=0, all type flags 0.
- rd=x0 forces rd_we=0.
- Immediates: I/S/B/U/J formats, sign-extended to 32 bits. B and J immediates have bit0=0. U-type is {instr[31:12],12'b0}.

Decomposition:
- rv32i_pkg holds the func-code localparams, opcode constants, and the src-select encodings.
- One combinational sub-module, rv32i_imm_gen, takes the instruction and returns the 32-bit immediate.
- The decode logic and skid buffer stay in this module.

Test Plan:
- 0x002081B3 (ADD x3,x1,x2), out_ready=1 → next cycle out_func=0000, rs1=1, rs2=2, rd=3, src2_sel=0, rd_we=1.
- 0x407302B3 (SUB x5,x6,x7) → out_func=0001, rd=5. 0xFFF00093 (ADDI x1,x0,-1) → out_func=0000, imm=0xFFFFFFFF, src2_sel=1.
- 0x008000EF (JAL x1,+8) at pc 0x100 → out_func=1110, src1_sel=1, imm=8, is_jump=1, out_pc=0x100, rd_we=1.
- 0xFFFFFFFF → out_illegal=1, func=1111, rd_we=0. 0x00000073 (ECALL) → out_illegal=1.
- Back-pressure: stream 4 instrs with out_ready=0 for 3 cycles → in_ready drops after 2 accepted; with out_ready=1 all 4 emerge in order with none lost or duplicated.
- Flush with both entries full → out_valid=0 next cycle, in_ready=1. rst_n=0 mid-stream → out_valid=0 after that edge.
